// File: rtl/nios_oci_dct_trace_monitor_if.sv
// Trace drain stream between the DCT trace monitor (master) and its consumer (slave).
interface nios_oci_dct_trace_monitor_if #(
  parameter int unsigned DATA_W = 30
);
  logic [DATA_W-1:0] trace_data;
  logic              trace_valid;
  logic              trace_ready;

  modport master (output trace_data, output trace_valid, input trace_ready);
  modport slave  (input trace_data, input trace_valid, output trace_ready);
endinterface

// File: rtl/nios_oci_dct_trace_monitor.sv
// Captures each completed OCI DCT pack into a show-ahead FIFO drained over a valid/ready stream,
// and runs the end-of-test handshake. Optional macro NIOS_OCI_DCT_TIMESTAMP_EN prepends a capture timestamp.
module nios_oci_dct_trace_monitor #(
  parameter int unsigned DCT_WIDTH   = 30,
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned PACK_COUNT  = 15,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DROP_WIDTH  = 8,
  parameter int unsigned TS_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DCT_WIDTH-1:0]          dct_buffer,
  input  logic [COUNT_WIDTH-1:0]        dct_count,
  input  logic                          trace_enable,
  input  logic                          test_ending,
  nios_oci_dct_trace_monitor_if.master  trace_if,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic [DROP_WIDTH-1:0]         drop_count,
  output logic                          test_has_ended
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = TS_WIDTH + DCT_WIDTH;
`else
  localparam int unsigned ENTRY_W = DCT_WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ENDED = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [COUNT_WIDTH-1:0] r_prev_count;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [FILL_W-1:0]      r_fill;
  logic [FILL_W-1:0]      w_fill_next;
  logic                   r_valid;
  logic                   r_overflow;
  logic [DROP_WIDTH-1:0]  r_drop_count;
  logic                   r_ended;
  logic [ENTRY_W-1:0]     r_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]     w_entry;

  logic w_pack_event;
  logic w_push_req;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A held PACK_COUNT yields a single event: only the rising transition into it counts.
  assign w_pack_event = (dct_count == COUNT_WIDTH'(PACK_COUNT)) &&
                        (r_prev_count != COUNT_WIDTH'(PACK_COUNT));
  assign w_push_req   = w_pack_event && (r_state == RUN);
  assign w_full       = (r_fill == FILL_W'(FIFO_DEPTH));
  assign w_pop        = r_valid && trace_if.trace_ready;
  assign w_push       = w_push_req && (!w_full || w_pop);
  assign w_drop       = w_push_req && w_full && !w_pop;

`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;

  // Free-running capture clock; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  assign w_entry = {r_ts, dct_buffer};
`else
  assign w_entry = dct_buffer;
`endif

  always_comb begin
    w_fill_next = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_next = r_fill + FILL_W'(1);
      2'b01:   w_fill_next = r_fill - FILL_W'(1);
      default: w_fill_next = r_fill;
    endcase
  end

  // Next-state logic; test_ending outranks trace_enable out of IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (test_ending)       w_next_state = DRAIN;
        else if (trace_enable) w_next_state = RUN;
      end
      RUN: begin
        if (test_ending)        w_next_state = DRAIN;
        else if (!trace_enable) w_next_state = IDLE;
      end
      DRAIN: begin
        if (r_fill == '0) w_next_state = ENDED;
      end
      ENDED:   w_next_state = ENDED;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_ended      <= 1'b0;
    end else begin
      r_prev_count <= dct_count;
      r_fill       <= w_fill_next;
      r_valid      <= (w_fill_next != '0);
      r_ended      <= (w_next_state == ENDED);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_WIDTH'(1);
      end
    end
  end

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign trace_if.trace_valid = r_valid;
  assign trace_if.trace_data  = r_valid ? r_mem[r_rd_ptr] : '0;
  assign fill_level           = r_fill;
  assign overflow             = r_overflow;
  assign drop_count           = r_drop_count;
  assign test_has_ended       = r_ended;

endmodule

// File: tb/tb_nios_oci_dct_trace_monitor.sv
// Directed bench for nios_oci_dct_trace_monitor: capture, hold, overflow, saturation, drain and reset.
module tb_nios_oci_dct_trace_monitor;

  localparam int unsigned DCT_W  = 30;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned TS_W   = 16;
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = DCT_W + TS_W;
`else
  localparam int unsigned ENTRY_W = DCT_W;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [DCT_W-1:0]        dct_buffer;
  logic [CNT_W-1:0]        dct_count;
  logic                    trace_enable;
  logic                    test_ending;
  logic [$clog2(DEPTH):0]  fill_level;
  logic                    overflow;
  logic [DROP_W-1:0]       drop_count;
  logic                    test_has_ended;

  nios_oci_dct_trace_monitor_if #(.DATA_W(ENTRY_W)) trace_if ();

  nios_oci_dct_trace_monitor #(
    .DCT_WIDTH   (DCT_W),
    .COUNT_WIDTH (CNT_W),
    .PACK_COUNT  (15),
    .FIFO_DEPTH  (DEPTH),
    .DROP_WIDTH  (DROP_W),
    .TS_WIDTH    (TS_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .trace_enable   (trace_enable),
    .test_ending    (test_ending),
    .trace_if       (trace_if),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pack: count steps 14 -> 15; the event edge samples d.
  task automatic pack(input logic [DCT_W-1:0] d);
    dct_count = 4'd14;
    step();
    dct_count  = 4'd15;
    dct_buffer = d;
    step();
  endtask

  function automatic logic [63:0] head_lo();
    return 64'(trace_if.trace_data[DCT_W-1:0]);
  endfunction

  initial begin
    reset_n              = 1'b0;
    dct_buffer           = '0;
    dct_count            = '0;
    trace_enable         = 1'b0;
    test_ending          = 1'b0;
    trace_if.trace_ready = 1'b0;
    #12;
    check("rst_valid", 64'(trace_if.trace_valid), 64'd0);
    check("rst_data",  64'(trace_if.trace_data),  64'd0);
    check("rst_fill",  64'(fill_level),           64'd0);
    check("rst_ovf",   64'(overflow),             64'd0);
    check("rst_drop",  64'(drop_count),           64'd0);
    check("rst_ended", 64'(test_has_ended),       64'd0);
    reset_n = 1'b1;
    step();

    // Single capture with downstream ready
    trace_enable = 1'b1;
    step();
    dct_count = 4'd14;
    step();
    dct_count            = 4'd15;
    dct_buffer           = 30'h1234567;
    trace_if.trace_ready = 1'b1;
    step();
    check("cap_valid", 64'(trace_if.trace_valid), 64'd1);
    check("cap_data",  head_lo(),                 64'h1234567);
    check("cap_fill",  64'(fill_level),           64'd1);
    step();
    check("cap_drained_fill",  64'(fill_level),           64'd0);
    check("cap_drained_valid", 64'(trace_if.trace_valid), 64'd0);

    // Held count gives exactly one capture
    trace_if.trace_ready = 1'b0;
    dct_count            = 4'd0;
    step();
    dct_count  = 4'd15;
    dct_buffer = 30'h0ABCDEF;
    repeat (5) step();
    check("hold_fill", 64'(fill_level), 64'd1);
    check("hold_data", head_lo(),       64'h0ABCDEF);
    trace_if.trace_ready = 1'b1;
    step();
    check("hold_drain", 64'(fill_level), 64'd0);
    trace_if.trace_ready = 1'b0;

    // Fill to 16, one drop
    for (int i = 1; i <= 17; i++) pack(DCT_W'(i));
    check("full_fill",  64'(fill_level),           64'd16);
    check("full_valid", 64'(trace_if.trace_valid), 64'd1);
    check("full_ovf",   64'(overflow),             64'd1);
    check("full_drop",  64'(drop_count),           64'd1);
    check("full_head",  head_lo(),                 64'd1);

    // Push with simultaneous pop while full: no drop
    dct_count = 4'd14;
    step();
    dct_count            = 4'd15;
    dct_buffer           = 30'h99;
    trace_if.trace_ready = 1'b1;
    step();
    trace_if.trace_ready = 1'b0;
    check("pp_fill", 64'(fill_level), 64'd16);
    check("pp_drop", 64'(drop_count), 64'd1);
    check("pp_head", head_lo(),       64'd2);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) pack(30'h3FF);
    check("sat_drop", 64'(drop_count), 64'hFF);
    check("sat_ovf",  64'(overflow),   64'd1);
    check("sat_fill", 64'(fill_level), 64'd16);

    // Drain to 4 entries, enter DRAIN, then async reset mid-cycle
    trace_if.trace_ready = 1'b1;
    repeat (12) step();
    trace_if.trace_ready = 1'b0;
    check("pre_rst_fill", 64'(fill_level), 64'd4);
    check("pre_rst_head", head_lo(),       64'd14);
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    step();
    check("drain_hold_fill", 64'(fill_level), 64'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(trace_if.trace_valid), 64'd0);
    check("arst_data",  64'(trace_if.trace_data),  64'd0);
    check("arst_fill",  64'(fill_level),           64'd0);
    check("arst_ovf",   64'(overflow),             64'd0);
    check("arst_drop",  64'(drop_count),           64'd0);
    check("arst_ended", 64'(test_has_ended),       64'd0);
    dct_count = 4'd0;
    #1;
    reset_n = 1'b1;

    // Fresh run: 3 entries, first captured on the 11th edge after reset
    repeat (9) step();
    dct_count = 4'd14;
    step();
    dct_count  = 4'd15;
    dct_buffer = 30'hA;
    step();
    check("ts_run_fill", 64'(fill_level), 64'd1);
    check("ts_run_data", head_lo(),       64'hA);
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
    check("ts_field", 64'(trace_if.trace_data[ENTRY_W-1:DCT_W]), 64'd10);
`endif
    pack(30'hB);
    pack(30'hC);
    check("q3_fill", 64'(fill_level), 64'd3);
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    pack(30'hD);
    check("drain_nocap_fill", 64'(fill_level),     64'd3);
    check("drain_ended0",     64'(test_has_ended), 64'd0);
    check("drain_head",       head_lo(),           64'hA);
    trace_if.trace_ready = 1'b1;
    step();
    check("pop1_fill", 64'(fill_level), 64'd2);
    check("pop1_head", head_lo(),       64'hB);
    step();
    check("pop2_fill", 64'(fill_level), 64'd1);
    check("pop2_head", head_lo(),       64'hC);
    step();
    check("pop3_fill",   64'(fill_level),           64'd0);
    check("pop3_valid",  64'(trace_if.trace_valid), 64'd0);
    check("pop3_ended0", 64'(test_has_ended),       64'd0);
    step();
    check("ended_set", 64'(test_has_ended), 64'd1);
    trace_if.trace_ready = 1'b0;
    pack(30'hE);
    repeat (3) step();
    check("ended_sticky", 64'(test_has_ended), 64'd1);
    check("ended_nocap",  64'(fill_level),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_oci_dct_trace_monitor.md
Name: nios_oci_dct_trace_monitor

Overview:
Parametrised successor to the passive OCI debug-capture test-bench stub. It watches the OCI data-capture-trace (DCT) buffer and fill count, and captures each completed DCT pack into a FIFO. The FIFO drains over a valid/ready stream. The block also drives its own end-of-test handshake, asserting test_has_ended only after all captured trace has drained. It sits beside the Nios II OCI in simulation and debug builds.

Parameters:
DCT_WIDTH, 30, width of dct_buffer and of each captured entry.
COUNT_WIDTH, 4, width of dct_count.
PACK_COUNT, 15, dct_count value that marks a completed pack (must be < 2**COUNT_WIDTH).
FIFO_DEPTH, 16, number of capture entries; power of two, >= 2.
DROP_WIDTH, 8, width of the saturating drop counter.
TS_WIDTH, 16, timestamp width (used only with the optional feature).

Ports:
clk  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
dct_buffer  in  DCT_WIDTH  OCI DCT shift buffer.
dct_count  in  COUNT_WIDTH  OCI DCT fill count.
trace_enable  in  1  capture enable (level).
test_ending  in  1  request to finish the test (level or pulse).
trace_ready  in  1  downstream accepts the head entry.
trace_data  out  DCT_WIDTH (+TS_WIDTH with option)  head entry.
trace_valid  out  1  head entry present.
fill_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky; set when a pack is dropped.
drop_count  out  DROP_WIDTH  number of dropped packs, saturating.
test_has_ended  out  1  end-of-test done; sticky until reset.

Behaviour:
- Reset (reset_n=0, asynchronous): FSM=IDLE and FIFO empty. All outputs are 0; trace_data is 0. The prev_count register resets to 0.
- Pack event: dct_count==PACK_COUNT && prev_count!=PACK_COUNT, sampled on the clk edge. prev_count<=dct_count every cycle. A count held at PACK_COUNT produces one event only.
- Capture: a pack event is pushed only in state RUN. dct_buffer is sampled on the same edge as the event.
- Latency: if the FIFO was empty, trace_valid=1 and trace_data=entry on the cycle after the event edge.
- Output: show-ahead. trace_valid = FIFO not empty. A pop occurs when trace_valid && trace_ready. trace_data is stable while trace_valid && !trace_ready.
- Full FIFO, push with a simultaneous pop: both occur, fill_level is unchanged, no drop.
- Full FIFO, push without a pop: the entry is discarded. overflow<=1 and drop_count increments, saturating at all-ones.
- Empty FIFO: a pop is impossible because trace_valid=0. A push and a "pop" on the same cycle is just a push.
- Pointers wrap modulo FIFO_DEPTH. fill_level ranges 0..FIFO_DEPTH.
- FSM:
  - IDLE: trace_enable=1 -> RUN; test_ending=1 -> DRAIN (test_ending has priority).
  - RUN: test_ending=1 -> DRAIN; trace_enable=0 -> IDLE. Draining continues in every state.
  - DRAIN: no captures. When fill_level==0 -> ENDED.
  - ENDED: test_has_ended=1 on the entry cycle and held. No captures. Exit only by reset.
- test_ending is sampled per cycle. A one-cycle pulse is sufficient.
- A pack event on the same cycle as test_ending in RUN is still captured, because the push decision uses the current state.
- Reset mid-drain: the FIFO is flushed, counters clear, and the FSM returns to IDLE immediately. No stale trace_valid.

Optional Feature:
NIOS_OCI_DCT_TIMESTAMP_EN
- Defined: a free-running TS_WIDTH counter, reset to 0, increments every clk and wraps. Each entry stores {timestamp_at_capture, dct_buffer}, so trace_data is DCT_WIDTH+TS_WIDTH bits with the timestamp in the MSBs.
- Undefined: no counter; trace_data is DCT_WIDTH bits.

Test Plan:
- Reset, then trace_enable=1. dct_count steps 14->15 with dct_buffer=30'h1234567 and trace_ready=1. Required: trace_valid=1 one cycle later with trace_data=30'h1234567, then fill_level returns to 0.
- dct_count held at 15 for 5 cycles. Required: exactly one entry is captured.
- trace_ready=0, then 17 pack events. Required: fill_level=16, overflow=1, drop_count=1, trace_data equals the first entry. A 16th-entry push with a simultaneous pop when full: no drop.
- 300 pack events with trace_ready=0. Required: drop_count saturates at 8'hFF.
- 3 entries queued with trace_ready=0, then a test_ending pulse, then a further pack event. Required: the pack is not captured and test_has_ended=0. Then trace_ready=1: 3 pops, and test_has_ended=1 on the cycle after fill_level reaches 0, sticky.
- reset_n asserted while in DRAIN with 4 entries. Required: trace_valid, fill_level and test_has_ended are 0 immediately (asynchronously). With NIOS_OCI_DCT_TIMESTAMP_EN, an entry captured 10 cycles after reset has timestamp field 10.
